// File: rtl/vga_text_pkg.sv
// Shared constants, character codes and FSM state type for the 80x30 text-mode renderer.
package vga_text_pkg;
    localparam int COLS    = 80;
    localparam int ROWS    = 30;
    localparam int GLYPH_W = 8;
    localparam int GLYPH_H = 16;
    localparam int CELLS   = COLS * ROWS;

    localparam logic [7:0] CH_SPACE = 8'h20;
    localparam logic [7:0] CH_LF    = 8'h0A;
    localparam logic [7:0] CH_BS    = 8'h08;
    localparam logic [7:0] CH_TILDE = 8'h7E;

    typedef enum logic [1:0] {
        ST_CLEAR_ALL = 2'd0,
        ST_IDLE      = 2'd1,
        ST_CLEAR_ROW = 2'd2
    } state_t;

    function automatic logic [11:0] cell_index(input logic [5:0] row, input logic [6:0] col);
        return 12'(row) * 12'(COLS) + 12'(col);
    endfunction

    function automatic logic is_printable(input logic [7:0] ch);
        return (ch >= CH_SPACE) && (ch <= CH_TILDE);
    endfunction
endpackage

// File: rtl/vga_font_rom.sv
// 4096x8 synchronous-read font ROM addressed by {char, glyph_row}. 'A' and 'B' carry real
// glyphs; every other printable code except space renders as a hollow box, the rest are blank.
module vga_font_rom
    import vga_text_pkg::*;
(
    input  logic        i_clk,
    input  logic [11:0] i_addr,
    output logic [7:0]  o_data
);
    logic [7:0] data_q, data_d;
    logic [7:0] ch;
    logic [3:0] grow;

    always_comb begin
        ch     = i_addr[11:4];
        grow   = i_addr[3:0];
        data_d = 8'h00;
        case (ch)
            8'h41: begin
                case (grow)
                    4'd2:                                 data_d = 8'h10;
                    4'd3:                                 data_d = 8'h38;
                    4'd4:                                 data_d = 8'h6C;
                    4'd5, 4'd6, 4'd8, 4'd9, 4'd10, 4'd11: data_d = 8'hC6;
                    4'd7:                                 data_d = 8'hFE;
                    default:                              data_d = 8'h00;
                endcase
            end
            8'h42: begin
                case (grow)
                    4'd2, 4'd11:                               data_d = 8'hFC;
                    4'd3, 4'd4, 4'd5, 4'd7, 4'd8, 4'd9, 4'd10: data_d = 8'h66;
                    4'd6:                                      data_d = 8'h7C;
                    default:                                   data_d = 8'h00;
                endcase
            end
            default: begin
                if (is_printable(ch) && (ch != CH_SPACE)) begin
                    if ((grow == 4'd2) || (grow == 4'd11)) begin
                        data_d = 8'h7E;
                    end else if ((grow >= 4'd3) && (grow <= 4'd10)) begin
                        data_d = 8'h42;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        data_q <= data_d;
    end

    assign o_data = data_q;
endmodule

// File: rtl/vga_text_render.sv
// 80x30 text-mode renderer: character RAM behind a terminal-style write port and a 2-cycle
// pixel pipeline. Defining VGA_TEXT_CURSOR_EN adds a blinking underline cursor.
module vga_text_render
    import vga_text_pkg::*;
#(
    parameter logic [23:0] FG_COLOR = 24'hFFFFFF,
    parameter logic [23:0] BG_COLOR = 24'h000000
) (
    input  logic        i_pclk,
    input  logic        i_reset,
    input  logic [9:0]  i_h_addr,
    input  logic [9:0]  i_v_addr,
    input  logic        i_valid,
    input  logic        i_wr_valid,
    input  logic [7:0]  i_wr_char,
    output logic        o_wr_ready,
    output logic [23:0] o_vga_data
);
    state_t      state_q, state_d;
    logic [6:0]  col_q, col_d;
    logic [4:0]  row_q, row_d;
    logic [11:0] clr_cnt_q, clr_cnt_d;
    logic [4:0]  next_row;
    logic        wr_printable;

    logic        ram_we;
    logic [11:0] ram_waddr;
    logic [7:0]  ram_wdata;
    logic [7:0]  char_ram [CELLS];

    logic [11:0] rd_addr;
    logic [7:0]  char_q, char_d;
    logic        valid1_q, valid1_d, valid2_q, valid2_d;
    logic [2:0]  hbit1_q, hbit1_d, hbit2_q, hbit2_d;
    logic [3:0]  grow1_q, grow1_d;
    logic [7:0]  font_row;
    logic        pixel_on;

    assign next_row     = (row_q == 5'(ROWS - 1)) ? 5'd0 : row_q + 5'd1;
    assign wr_printable = is_printable(i_wr_char);
    assign rd_addr      = cell_index(6'(i_v_addr / 10'(GLYPH_H)), 7'(i_h_addr / 10'(GLYPH_W)));

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_pclk or posedge i_reset) begin
        if (i_reset) begin
            state_q   <= ST_CLEAR_ALL;
            col_q     <= '0;
            row_q     <= '0;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            col_q     <= col_d;
            row_q     <= row_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    // NOTE: every signal gets a default before the case, so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        col_d     = col_q;
        row_d     = row_q;
        clr_cnt_d = clr_cnt_q;
        case (state_q)
            ST_CLEAR_ALL: begin
                if (clr_cnt_q == 12'(CELLS - 1)) begin
                    clr_cnt_d = '0;
                    state_d   = ST_IDLE;
                end else begin
                    clr_cnt_d = clr_cnt_q + 12'd1;
                end
            end
            ST_CLEAR_ROW: begin
                if (clr_cnt_q == 12'(COLS - 1)) begin
                    clr_cnt_d = '0;
                    state_d   = ST_IDLE;
                end else begin
                    clr_cnt_d = clr_cnt_q + 12'd1;
                end
            end
            ST_IDLE: begin
                if (i_wr_valid) begin
                    // Any row advance moves the cursor to the new row and blanks it.
                    if ((wr_printable && (col_q == 7'(COLS - 1))) || (i_wr_char == CH_LF)) begin
                        col_d   = '0;
                        row_d   = next_row;
                        state_d = ST_CLEAR_ROW;
                    end else if (wr_printable) begin
                        col_d = col_q + 7'd1;
                    end else if ((i_wr_char == CH_BS) && (col_q != '0)) begin
                        col_d = col_q - 7'd1;
                    end
                end
            end
            default: state_d = ST_CLEAR_ALL;
        endcase
    end

    always_comb begin
        o_wr_ready = (state_q == ST_IDLE);
        ram_we     = 1'b0;
        ram_waddr  = '0;
        ram_wdata  = CH_SPACE;
        case (state_q)
            ST_CLEAR_ALL: begin
                ram_we    = 1'b1;
                ram_waddr = clr_cnt_q;
            end
            ST_CLEAR_ROW: begin
                ram_we    = 1'b1;
                ram_waddr = cell_index({1'b0, row_q}, 7'd0) + clr_cnt_q;
            end
            ST_IDLE: begin
                if (i_wr_valid && wr_printable) begin
                    ram_we    = 1'b1;
                    ram_waddr = cell_index({1'b0, row_q}, col_q);
                    ram_wdata = i_wr_char;
                end else if (i_wr_valid && (i_wr_char == CH_BS) && (col_q != '0)) begin
                    ram_we    = 1'b1;
                    ram_waddr = cell_index({1'b0, row_q}, col_q - 7'd1);
                end
            end
            default: ram_we = 1'b0;
        endcase
    end

    // NOTE: the character RAM has no reset; CLEAR_ALL initialises it so it can map onto block RAM.
    always_ff @(posedge i_pclk) begin
        if (ram_we) begin
            char_ram[ram_waddr] <= ram_wdata;
        end
    end

    always_comb begin
        char_d   = char_ram[rd_addr];
        valid1_d = i_valid;
        hbit1_d  = i_h_addr[2:0];
        grow1_d  = i_v_addr[3:0];
        valid2_d = valid1_q;
        hbit2_d  = hbit1_q;
    end

    always_ff @(posedge i_pclk) begin
        char_q <= char_d;
    end

    always_ff @(posedge i_pclk or posedge i_reset) begin
        if (i_reset) begin
            valid1_q <= 1'b0;
            valid2_q <= 1'b0;
            hbit1_q  <= '0;
            hbit2_q  <= '0;
            grow1_q  <= '0;
        end else begin
            valid1_q <= valid1_d;
            valid2_q <= valid2_d;
            hbit1_q  <= hbit1_d;
            hbit2_q  <= hbit2_d;
            grow1_q  <= grow1_d;
        end
    end

    vga_font_rom u_font_rom (
        .i_clk  (i_pclk),
        .i_addr ({char_q, grow1_q}),
        .o_data (font_row)
    );

`ifdef VGA_TEXT_CURSOR_EN
    logic [22:0] blink_q, blink_d;
    logic        cursor1_q, cursor1_d, cursor2_q, cursor2_d;

    // Underline covers the last two glyph rows of the cursor cell while the blink MSB is low.
    always_comb begin
        blink_d   = blink_q + 23'd1;
        cursor1_d = (rd_addr == cell_index({1'b0, row_q}, col_q))
                    && (i_v_addr[3:0] >= 4'(GLYPH_H - 2)) && !blink_q[22];
        cursor2_d = cursor1_q;
    end

    always_ff @(posedge i_pclk or posedge i_reset) begin
        if (i_reset) begin
            blink_q   <= '0;
            cursor1_q <= 1'b0;
            cursor2_q <= 1'b0;
        end else begin
            blink_q   <= blink_d;
            cursor1_q <= cursor1_d;
            cursor2_q <= cursor2_d;
        end
    end
`endif

    always_comb begin
        pixel_on = font_row[3'd7 - hbit2_q];
`ifdef VGA_TEXT_CURSOR_EN
        pixel_on = pixel_on | cursor2_q;
`endif
        o_vga_data = valid2_q ? (pixel_on ? FG_COLOR : BG_COLOR) : 24'h000000;
    end
endmodule

// File: tb/tb_vga_text_render.sv
// Self-checking bench for vga_text_render: a cell-array terminal model predicts every pixel.
module tb_vga_text_render;
    localparam logic [23:0] FG = 24'hF0E0D0;
    localparam logic [23:0] BG = 24'h102030;
    localparam int M_CELL = 0;
    localparam int M_RAND = 1;
    localparam int M_ROW  = 2;

    logic        i_pclk = 1'b0;
    logic        i_reset = 1'b1;
    logic [9:0]  i_h_addr = '0;
    logic [9:0]  i_v_addr = '0;
    logic        i_valid = 1'b0;
    logic        i_wr_valid = 1'b0;
    logic [7:0]  i_wr_char = '0;
    logic        o_wr_ready;
    logic [23:0] o_vga_data;

    int checks = 0;
    int failures = 0;

    logic [7:0] model_ram [2400];
    int cur_row;
    int cur_col;

    logic [7:0] glyph_a [16] = '{8'h00, 8'h00, 8'h10, 8'h38, 8'h6C, 8'hC6, 8'hC6, 8'hFE,
                                 8'hC6, 8'hC6, 8'hC6, 8'hC6, 8'h00, 8'h00, 8'h00, 8'h00};
    logic [7:0] glyph_b [16] = '{8'h00, 8'h00, 8'hFC, 8'h66, 8'h66, 8'h66, 8'h7C, 8'h66,
                                 8'h66, 8'h66, 8'h66, 8'hFC, 8'h00, 8'h00, 8'h00, 8'h00};

    vga_text_render #(
        .FG_COLOR (FG),
        .BG_COLOR (BG)
    ) dut (
        .i_pclk     (i_pclk),
        .i_reset    (i_reset),
        .i_h_addr   (i_h_addr),
        .i_v_addr   (i_v_addr),
        .i_valid    (i_valid),
        .i_wr_valid (i_wr_valid),
        .i_wr_char  (i_wr_char),
        .o_wr_ready (o_wr_ready),
        .o_vga_data (o_vga_data)
    );

    always #5 i_pclk = ~i_pclk;

    initial begin
        #900000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [7:0] ref_glyph(input logic [7:0] ch, input int r);
        if (ch == 8'h41) return glyph_a[r];
        if (ch == 8'h42) return glyph_b[r];
        if (ch > 8'h20 && ch < 8'h7F) begin
            if (r == 2 || r == 11) return 8'h7E;
            if (r > 2 && r < 11) return 8'h42;
        end
        return 8'h00;
    endfunction

    function automatic logic [23:0] ref_pixel(input int h, input int v, input logic valid);
        logic [7:0] g;
        if (!valid) return 24'h000000;
        g = ref_glyph(model_ram[(v / 16) * 80 + h / 8], v % 16);
        return g[7 - h % 8] ? FG : BG;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2400; i++) model_ram[i] = 8'h20;
        cur_row = 0;
        cur_col = 0;
    endtask

    task automatic model_write(input logic [7:0] ch, output bit adv);
        adv = 1'b0;
        if (ch >= 8'h20 && ch <= 8'h7E) begin
            model_ram[cur_row * 80 + cur_col] = ch;
            if (cur_col == 79) adv = 1'b1;
            else cur_col++;
        end else if (ch == 8'h0A) begin
            adv = 1'b1;
        end else if (ch == 8'h08 && cur_col > 0) begin
            cur_col--;
            model_ram[cur_row * 80 + cur_col] = 8'h20;
        end
        if (adv) begin
            cur_col = 0;
            cur_row = (cur_row + 1) % 30;
            for (int c = 0; c < 80; c++) model_ram[cur_row * 80 + c] = 8'h20;
        end
    endtask

    // Called just after an edge while o_wr_ready is low; counts edges until it rises.
    task automatic count_busy(input int expected, input string name);
        int n;
        n = 0;
        while (!o_wr_ready && n < 5000) begin
            @(posedge i_pclk);
            #1;
            n++;
        end
        checks++;
        if (n != expected) begin
            failures++;
            $display("FAIL %s: busy cycles actual=%0d expected=%0d", name, n, expected);
        end
    endtask

    task automatic write_char(input logic [7:0] ch);
        int n;
        bit adv;
        n = 0;
        @(negedge i_pclk);
        i_wr_valid = 1'b1;
        i_wr_char  = ch;
        while (!o_wr_ready && n < 3000) begin
            @(negedge i_pclk);
            n++;
        end
        checks++;
        if (!o_wr_ready) begin
            failures++;
            $display("FAIL write_ready_timeout: ch=%h o_wr_ready=%b expected=1", ch, o_wr_ready);
            i_wr_valid = 1'b0;
            return;
        end
        @(posedge i_pclk);
        #1;
        i_wr_valid = 1'b0;
        model_write(ch, adv);
        if (adv) count_busy(80, "clear_row");
    endtask

    task automatic stream_pixels(input int count, input int mode, input int cell_r,
                                 input int cell_c, input string name);
        logic [23:0] exp_q [$];
        logic [23:0] e;
        int h;
        int v;
        logic val;
        for (int i = 0; i < count + 2; i++) begin
            @(negedge i_pclk);
            if (i >= 2) begin
                e = exp_q.pop_front();
                checks++;
                if (o_vga_data !== e) begin
                    failures++;
                    $display("FAIL %s: pixel %0d o_vga_data=%h expected=%h", name, i - 2, o_vga_data, e);
                end
            end
            if (i < count) begin
                if (mode == M_CELL) begin
                    h = cell_c * 8 + i % 8;
                    v = cell_r * 16 + (i / 8) % 16;
                    val = 1'b1;
                end else if (mode == M_RAND) begin
                    h = int'($urandom_range(0, 639));
                    v = int'($urandom_range(0, 479));
                    val = ($urandom_range(0, 7) != 0);
                end else begin
                    h = int'($urandom_range(0, 639));
                    v = cell_r * 16 + int'($urandom_range(0, 15));
                    val = 1'b1;
                end
                i_h_addr = 10'(h);
                i_v_addr = 10'(v);
                i_valid  = val;
                exp_q.push_back(ref_pixel(h, v, val));
            end else begin
                i_valid = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        i_reset = 1'b1;
        repeat (3) @(negedge i_pclk);
        checks++;
        if (o_wr_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_ready: o_wr_ready=%b expected=0", o_wr_ready);
        end
        checks++;
        if (o_vga_data !== 24'h000000) begin
            failures++;
            $display("FAIL reset_pixel: o_vga_data=%h expected=000000", o_vga_data);
        end
        i_wr_valid = 1'b1;
        i_wr_char  = 8'h01;
        i_reset    = 1'b0;
        model_reset();
        count_busy(2400, "clear_all");
        @(negedge i_pclk);
        i_wr_valid = 1'b0;
        stream_pixels(300, M_RAND, 0, 0, "blank_screen");
    endtask

    task automatic test_glyph();
        write_char(8'h41);
        stream_pixels(128, M_CELL, 0, 0, "glyph_a");
        write_char(8'h42);
        stream_pixels(128, M_CELL, 0, 1, "cursor_advance");
        write_char(8'h01);
        write_char(8'h7F);
        write_char(8'hFF);
        write_char(8'h41);
        stream_pixels(128, M_CELL, 0, 2, "ignored_codes");
        stream_pixels(128, M_CELL, 0, 3, "next_cell_blank");
    endtask

    task automatic test_row_fill();
        repeat (3) write_char(8'h08);
        stream_pixels(128, M_CELL, 0, 0, "bs_to_col0");
        repeat (80) write_char(8'h41);
        stream_pixels(150, M_ROW, 0, 0, "row0_full");
        stream_pixels(150, M_ROW, 1, 0, "row1_blank");
    endtask

    task automatic test_backspace();
        write_char(8'h08);
        write_char(8'h42);
        stream_pixels(128, M_CELL, 1, 0, "bs_at_col0");
        write_char(8'h08);
        stream_pixels(128, M_CELL, 1, 0, "bs_erase");
        write_char(8'h41);
        stream_pixels(128, M_CELL, 1, 0, "bs_cursor_home");
    endtask

    task automatic test_newline_wrap();
        repeat (30) write_char(8'h0A);
        stream_pixels(200, M_ROW, 0, 0, "wrap_row0_cleared");
        write_char(8'h42);
        stream_pixels(128, M_CELL, 1, 0, "wrap_cursor");
        stream_pixels(200, M_RAND, 0, 0, "wrap_screen");
    endtask

    task automatic test_random_writes();
        int r;
        logic [7:0] ch;
        for (int i = 0; i < 60; i++) begin
            r = int'($urandom_range(0, 19));
            if (r < 6) ch = 8'h41;
            else if (r < 10) ch = 8'h42;
            else if (r < 13) ch = 8'($urandom_range(32, 126));
            else if (r < 15) ch = 8'h0A;
            else if (r < 18) ch = 8'h08;
            else if (r < 19) ch = 8'($urandom_range(0, 31));
            else ch = 8'($urandom_range(127, 255));
            write_char(ch);
        end
        stream_pixels(400, M_RAND, 0, 0, "random_screen");
        stream_pixels(150, M_ROW, cur_row, 0, "random_cursor_row");
    endtask

    task automatic test_reset_mid_clear();
        int n;
        int pr;
        bit adv;
        logic [23:0] e;
        n = 0;
        write_char(8'h42);
        @(negedge i_pclk);
        i_wr_valid = 1'b1;
        i_wr_char  = 8'h0A;
        while (!o_wr_ready && n < 3000) begin
            @(negedge i_pclk);
            n++;
        end
        @(posedge i_pclk);
        #1;
        i_wr_valid = 1'b0;
        model_write(8'h0A, adv);
        repeat (20) @(posedge i_pclk);
        pr = (cur_row + 29) % 30;
        @(negedge i_pclk);
        i_h_addr = 10'd0;
        i_v_addr = 10'(pr * 16 + 5);
        i_valid  = 1'b1;
        e = ref_pixel(0, pr * 16 + 5, 1'b1);
        @(negedge i_pclk);
        @(negedge i_pclk);
        checks++;
        if (o_vga_data !== e) begin
            failures++;
            $display("FAIL pixel_during_clear: o_vga_data=%h expected=%h", o_vga_data, e);
        end
        i_valid = 1'b0;
        #2;
        i_reset = 1'b1;
        #1;
        checks++;
        if (o_vga_data !== 24'h000000) begin
            failures++;
            $display("FAIL async_reset_pixel: o_vga_data=%h expected=000000", o_vga_data);
        end
        checks++;
        if (o_wr_ready !== 1'b0) begin
            failures++;
            $display("FAIL async_reset_ready: o_wr_ready=%b expected=0", o_wr_ready);
        end
        @(negedge i_pclk);
        i_reset = 1'b0;
        model_reset();
        count_busy(2400, "clear_all_restart");
        stream_pixels(300, M_RAND, 0, 0, "post_reset_blank");
        write_char(8'h41);
        stream_pixels(128, M_CELL, 0, 0, "post_reset_home");
    endtask

    initial begin
        test_reset();
        test_glyph();
        test_row_fill();
        test_backspace();
        test_newline_wrap();
        test_random_writes();
        test_reset_mid_clear();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
